// File: rtl/sevseg_pkg.sv
// sevseg_pkg: register map, display modes, glyph table and double-dabble helper
// shared by the seven-segment controller and its BCD converter.
package sevseg_pkg;
    localparam logic [1:0] REG_CTRL = 2'd0, REG_VALUE = 2'd1, REG_DP = 2'd2, REG_STATUS = 2'd3;
    localparam logic [1:0] MODE_RAW = 2'd0, MODE_HEX = 2'd1, MODE_DEC = 2'd2;
    localparam logic [7:0] DASH = 8'h40;
    localparam logic [15:0][7:0] GLYPHS = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} cvt_state_t;
    function automatic logic [7:0] glyph(input logic [3:0] d);
        return GLYPHS[d];
    endfunction
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[4*i +: 4] = b[4*i +: 4] > 4'd4 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/sevseg_ctrl_if.sv
// sevseg_ctrl_if: PicoSoC iomem bus between the CPU and sevseg_ctrl.
interface sevseg_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    modport master(output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
    modport slave(input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/sevseg_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, 10-bit binary to 3-digit BCD.
// done_o strobes in the last SHIFT cycle with bcd_o carrying the finished word.
module bin2bcd_seq import sevseg_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [9:0]  bin_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);
    cvt_state_t state_q, state_d;
    logic [9:0] bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d, adj;
    logic [3:0] cnt_q, cnt_d;
    assign adj = dd_adjust(bcd_q);
    assign busy_o = state_q != S_IDLE;
    assign done_o = state_q == S_SHIFT && cnt_q == 4'd9;
    assign bcd_o = bcd_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (state_q == S_LOAD) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = '0;
            state_d = S_SHIFT;
        end
        if (state_q == S_SHIFT) begin
            {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
            cnt_d = cnt_q + 4'd1;
            state_d = cnt_q == 4'd9 ? S_DONE : S_SHIFT;
        end
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start_i) state_d = S_LOAD;
        else if (abort_i) state_d = S_IDLE;
    end
endmodule

// File: rtl/sevseg_ctrl.sv
// sevseg_ctrl: iomem peripheral rendering a value as raw, hex or decimal segments
// for a 3-digit seven-segment multiplexer; data only moves when a render completes.
module sevseg_ctrl import sevseg_pkg::*; #(
    parameter logic [31:0] ADDR_BASE = 32'h0300_0000
) (
    input  logic         clk,
    input  logic         rst,
    sevseg_ctrl_if.slave bus,
    output logic [23:0]  data
);
    logic ready_q, trig_q, trig_d, ovf_q, ovf_d, hit, wr, busy, done, dec, hz, tz, ovf, unused;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic [23:0] value_q, value_d, data_q, data_d, dp_or, hex_seg, dec_seg;
    logic [2:0] dp_q, dp_d;
    logic [1:0] sel;
    logic [11:0] bcd;
    assign sel = bus.iomem_addr[3:2];
    assign hit = bus.iomem_valid && !ready_q && bus.iomem_addr[31:4] == ADDR_BASE[31:4];
    assign wr = hit && |bus.iomem_wstrb;
    assign dec = ctrl_q[1:0] == MODE_DEC && !ctrl_q[2];
    assign dp_or = {dp_q[2], 7'd0, dp_q[1], 7'd0, dp_q[0], 7'd0};
    assign hex_seg = {glyph(value_q[11:8]), glyph(value_q[7:4]), glyph(value_q[3:0])} | dp_or;
    assign hz = ctrl_q[3] && bcd[11:8] == 4'd0;
    assign tz = hz && bcd[7:4] == 4'd0;
    assign ovf = value_q[9:0] > 10'd999;
    assign dec_seg = (ovf ? {3{DASH}} : {hz ? 8'd0 : glyph(bcd[11:8]), tz ? 8'd0 : glyph(bcd[7:4]), glyph(bcd[3:0])}) | dp_or;
    assign unused = ^{bus.iomem_addr[1:0], bus.iomem_wstrb[3], bus.iomem_wdata[31:24]};
    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign data = data_q;
    // Every render-triggering write restarts the converter, so only the last value lands
    bin2bcd_seq u_cvt (
        .clk(clk), .rst(rst), .start_i(trig_q && dec), .abort_i(trig_q && !dec),
        .bin_i(value_q[9:0]), .busy_o(busy), .done_o(done), .bcd_o(bcd)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            trig_q <= 1'b0;
            ovf_q <= 1'b0;
            rdata_q <= '0;
            ctrl_q <= '0;
            value_q <= '0;
            dp_q <= '0;
            data_q <= '0;
        end else begin
            ready_q <= hit;
            trig_q <= trig_d;
            ovf_q <= ovf_d;
            rdata_q <= rdata_d;
            ctrl_q <= ctrl_d;
            value_q <= value_d;
            dp_q <= dp_d;
            data_q <= data_d;
        end
    end
    always_comb begin
        ctrl_d = ctrl_q;
        value_d = value_q;
        dp_d = dp_q;
        if (wr && sel == REG_CTRL && bus.iomem_wstrb[0]) ctrl_d = bus.iomem_wdata[3:0];
        if (wr && sel == REG_DP && bus.iomem_wstrb[0]) dp_d = bus.iomem_wdata[2:0];
        for (int i = 0; i < 3; i++)
            if (wr && sel == REG_VALUE && bus.iomem_wstrb[i]) value_d[8*i +: 8] = bus.iomem_wdata[8*i +: 8];
        trig_d = wr && sel != REG_STATUS;
        rdata_d = !hit ? 32'd0 : sel == REG_CTRL ? {28'd0, ctrl_q} : sel == REG_VALUE ? {8'd0, value_q} :
                  sel == REG_DP ? {29'd0, dp_q} : {30'd0, ovf_q, busy};
        data_d = data_q;
        ovf_d = ovf_q;
        if (trig_q && !dec) begin
            data_d = ctrl_q[2] ? 24'd0 : ctrl_q[1:0] == MODE_HEX ? hex_seg : value_q;
            ovf_d = 1'b0;
        end else if (done && !trig_q) begin
            data_d = dec_seg;
            ovf_d = ovf;
        end
    end
endmodule

// File: tb/tb_sevseg_ctrl.sv
// tb_sevseg_ctrl: directed stimulus with a scoreboard of expected bus responses
// and expected segment-word changes (value and arrival cycle).
module tb_sevseg_ctrl;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE, A_VALUE = BASE + 32'h4, A_DP = BASE + 32'h8, A_STATUS = BASE + 32'hC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [23:0] data;
    sevseg_ctrl_if bus ();
    sevseg_ctrl #(.ADDR_BASE(BASE)) dut (.clk(clk), .rst(rst), .bus(bus), .data(data));
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { string name; logic [23:0] val; int cyc; } dexp_t;
    typedef struct { string name; bit rd; logic [31:0] val; } bexp_t;
    dexp_t dq[$];
    bexp_t bq[$];
    dexp_t d;
    bexp_t b;
    bit mon_on = 1'b0;
    logic [23:0] last = 24'h0;
    int rdy_cnt = 0;
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string msg);
        checks++;
        $display("FAIL %s", msg);
    endtask

    always @(negedge clk) if (mon_on) begin
        if (bus.iomem_ready === 1'b1) begin
            rdy_cnt++;
            if (bq.size() == 0) fail($sformatf("unexpected_ready at cycle %0d", cyc));
            else begin
                b = bq.pop_front();
                if (b.rd) check(b.name, bus.iomem_rdata, b.val);
            end
        end
        if (data !== last) begin
            if (dq.size() == 0) fail($sformatf("unexpected_data: got %h at cycle %0d", data, cyc));
            else begin
                d = dq.pop_front();
                check(d.name, {8'd0, data}, {8'd0, d.val});
                check({d.name, "_cyc"}, cyc, d.cyc);
            end
            last = data;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] v, output int rc);
        bus.iomem_addr = a;
        bus.iomem_wstrb = s;
        bus.iomem_wdata = v;
        bus.iomem_valid = 1'b1;
        rc = -1;
        for (int i = 0; i < 8 && rc < 0; i++) begin
            @(posedge clk);
            #1;
            if (bus.iomem_ready === 1'b1) rc = cyc;
        end
        bus.iomem_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s, output int rc);
        bq.push_back('{"wr", 1'b0, 32'd0});
        access(a, s, v, rc);
        if (rc < 0) fail($sformatf("wr_ack timeout at %h", a));
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        int rc;
        bq.push_back('{name, 1'b1, exp});
        access(a, 4'h0, 32'd0, rc);
        if (rc < 0) fail($sformatf("%s ack timeout", name));
    endtask

    task automatic expect_data(input string name, input logic [23:0] v, input int c);
        dq.push_back('{name, v, c});
    endtask

    initial begin
        int rc;
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr = 32'h0;
        bus.iomem_wdata = 32'h0;
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", {8'd0, data}, 32'h0);
        check("reset_ready", {31'd0, bus.iomem_ready}, 32'h0);
        mon_on = 1'b1;
        cycles(20);
        check("idle_ready_count", rdy_cnt, 0);
        rd("status_reset", A_STATUS, 32'h0);
        // hex mode
        wr(A_CTRL, 32'h1, 4'hF, rc);
        expect_data("hex_zero", 24'h3F3F3F, rc + 1);
        wr(A_VALUE, 32'hA5F, 4'hF, rc);
        expect_data("hex_a5f", 24'h776D71, rc + 1);
        rd("rd_value", A_VALUE, 32'h0000_0A5F);
        // decimal mode; the CTRL-triggered conversion is superseded by the VALUE write
        wr(A_CTRL, 32'h2, 4'hF, rc);
        wr(A_VALUE, 32'd407, 4'hF, rc);
        expect_data("dec_407", 24'h663F07, rc + 12);
        rd("status_busy", A_STATUS, 32'h1);
        cycles(14);
        rd("status_idle", A_STATUS, 32'h0);
        wr(A_DP, 32'h2, 4'hF, rc);
        expect_data("dec_dp", 24'h66BF07, rc + 12);
        cycles(14);
        wr(A_DP, 32'h0, 4'hF, rc);
        expect_data("dec_nodp", 24'h663F07, rc + 12);
        cycles(14);
        wr(A_CTRL, 32'hA, 4'hF, rc);
        wr(A_VALUE, 32'd7, 4'hF, rc);
        expect_data("dec_lzb", 24'h000007, rc + 12);
        cycles(14);
        wr(A_VALUE, 32'd1000, 4'hF, rc);
        expect_data("dec_ovf", 24'h404040, rc + 12);
        cycles(14);
        rd("status_ovf", A_STATUS, 32'h2);
        wr(A_VALUE, 32'd123, 4'hF, rc);
        cycles(5);
        wr(A_VALUE, 32'd999, 4'hF, rc);
        expect_data("dec_retrig", 24'h6F6F6F, rc + 12);
        cycles(14);
        rd("status_clr", A_STATUS, 32'h0);
        wr(A_STATUS, 32'h3, 4'hF, rc);
        rd("status_wr_ignored", A_STATUS, 32'h0);
        // address decode, byte lanes, raw/blank/DP
        access(BASE + 32'h10, 4'h0, 32'h0, rc);
        check("no_ack_out_of_window", rc, -1);
        wr(A_CTRL, 32'h0, 4'hF, rc);
        expect_data("raw_3e7", 24'h0003E7, rc + 1);
        wr(A_VALUE, 32'h0, 4'hF, rc);
        expect_data("raw_zero", 24'h000000, rc + 1);
        wr(A_VALUE, 32'hFFFF_FFFF, 4'b0001, rc);
        expect_data("raw_lane0", 24'h0000FF, rc + 1);
        rd("rd_value_lane0", A_VALUE, 32'h0000_00FF);
        wr(A_DP, 32'h7, 4'hF, rc);
        cycles(3);
        rd("rd_dp", A_DP, 32'h7);
        wr(A_CTRL, 32'h4, 4'hF, rc);
        expect_data("blank", 24'h000000, rc + 1);
        wr(A_CTRL, 32'h0, 4'hF, rc);
        expect_data("unblank", 24'h0000FF, rc + 1);
        wr(A_CTRL, 32'h1, 4'hF, rc);
        expect_data("hex_dp", 24'hBFF1F1, rc + 1);
        rd("rd_ctrl", A_CTRL, 32'h1);
        // reset in the middle of a decimal conversion
        wr(A_CTRL, 32'h2, 4'hF, rc);
        cycles(5);
        rst = 1'b1;
        expect_data("rst_data", 24'h000000, cyc + 1);
        cycles(1);
        rst = 1'b0;
        rd("status_after_rst", A_STATUS, 32'h0);
        rd("ctrl_after_rst", A_CTRL, 32'h0);
        cycles(16);
        check("pending_data_expectations", dq.size(), 0);
        check("pending_bus_expectations", bq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/sevseg_ctrl.md
Name: sevseg_ctrl

Overview:
- Memory-mapped PicoSoC iomem peripheral that produces the 24-bit segment word consumed by the 3-digit seven-segment multiplexer.
- Firmware writes a value and a display mode. The block renders the value as raw segments, 3-digit hex, or 3-digit decimal, with per-digit decimal points.
- Decimal rendering uses a sequential double-dabble binary-to-BCD converter.
- The output is held stable and glitch-free between updates.

Parameters:
- ADDR_BASE, 32'h0300_0000, base byte address of the 16-byte register window (bits [3:2] select the register).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- iomem_valid  input  1  bus request
- iomem_ready  output  1  one-cycle acknowledge
- iomem_wstrb  input  4  byte write strobes; 0 means read
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_rdata  output  32  read data, valid while iomem_ready=1
- data  output  24  segment word to the multiplexer: [23:16] leftmost digit, [7:0] rightmost; per byte bit0..6 = seg a..g, bit7 = dp; active-high

Behaviour:
- Registers:
  - 0x0 CTRL: [1:0] mode (0 raw, 1 hex, 2 dec, 3 treated as raw), [2] blank, [3] leading-zero blank (dec only).
  - 0x4 VALUE: [23:0]. Raw uses [23:0], hex uses [11:0], dec uses [9:0].
  - 0x8 DP: [2:0]; bit2 = leftmost digit.
  - 0xC STATUS (read-only): [0] busy, [1] overflow.
  - Unused bits read 0.
- Bus protocol:
  - Address match when iomem_addr[31:4] == ADDR_BASE[31:4].
  - On match with valid=1 and ready=0, assert ready for exactly one cycle on the next clock. Writes take effect on that edge, honouring wstrb per byte lane.
  - Non-matching addresses: ready stays 0.
  - Writes to STATUS are ignored but still acknowledged.
- Render trigger: any acknowledged write to CTRL, VALUE or DP.
  - Raw and hex: data updates one clock after the ready cycle.
  - Dec: FSM IDLE -> LOAD (1 cycle) -> SHIFT (10 cycles) -> DONE (1 cycle) -> IDLE. data updates on DONE, 12 clocks after the ready cycle.
  - busy=1 from the cycle after ready until DONE inclusive.
  - data holds its previous value throughout conversion.
- Retrigger while busy: restart from LOAD with the new register contents. Only the final result reaches data.
- Dec overflow: VALUE[9:0] > 999 sets overflow=1 and renders 8'h40 on all three digits (dashes). Any in-range render clears overflow.
- Leading-zero blank: in dec mode with CTRL[3]=1, suppress leading zero digits (byte 0 before DP OR). The rightmost digit is never suppressed.
- Blank: CTRL[2]=1 forces data=0 one clock after the ready cycle and ignores DP. Clearing it re-renders.
- DP: OR DP[n] into bit7 of digit n in hex and dec modes. Raw mode ignores DP.
- Hex glyphs: 0-9 standard; A,b,C,d,E,F = 77,7C,39,5E,79,71.
- Reset: data=0, all registers 0, busy=0, overflow=0, iomem_ready=0, iomem_rdata=0, FSM IDLE. Reset mid-conversion aborts it; data=0.

Decomposition:
- Package sevseg_pkg:
  - register offsets
  - mode encodings
  - glyph constants
  - FSM state typedef
  - DASH = 8'h40
- Sub-module bin2bcd_seq: 10-bit input, start/busy/done handshake, 12-bit BCD out, sequential double dabble.
- Glyph encoding stays a function in the package.

Test Plan:
- Reset, then idle for 20 cycles -> data = 24'h000000, iomem_ready never asserted, STATUS reads 0.
- Write CTRL=1, VALUE=12'hA5F -> data = 24'h776D71 one clock after the VALUE ready cycle; read VALUE returns 32'h00000A5F.
- Write CTRL=2, VALUE=407 -> busy=1 for 12 clocks, then data = 24'h663F07. Write DP=3'b010 -> data = 24'h66BF07.
- Dec VALUE=7 with CTRL[3]=1 -> data = 24'h000007. Then VALUE=1000 -> data = 24'h404040 and STATUS = 2.
- Dec: write VALUE=123, then write VALUE=999 five cycles later -> data never shows 123; final data = 24'h6F6F6F, 12 clocks after the second ready.
- Access at ADDR_BASE+16 -> no ready. Write wstrb=4'b0001 with wdata=32'hFFFFFFFF to VALUE holding 0 -> VALUE = 32'h000000FF. Assert rst during SHIFT -> data = 0 and busy = 0 next cycle.
